// File: rtl/elastic_pipe.sv
// Valid/ready register chain of DEPTH stages with bubble collapsing, backpressure and flush.
// Stage DEPTH-1 drives the outputs; occupancy is a popcount of the stage valids.
module elastic_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 4,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] d     [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];

  // Stage i is ready when out_ready is high or any stage from i to the tail is empty;
  // this is the unrolled form of r[i] = ~v[i] | r[i+1].
  always_comb begin
    logic tail_full;
    r         = '0;
    tail_full = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      tail_full         = tail_full & v[DEPTH-1-k];
      r[DEPTH-1-k]      = out_ready | ~tail_full;
    end
  end

  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    src_d[0] = in_data;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      src_v[k] = v[k-1];
      src_d[k] = d[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v <= '0;
      if (CLEAR_DATA) begin
        for (int unsigned k = 0; k < DEPTH; k++) d[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (r[k]) begin
          v[k] <= src_v[k];
          if (src_v[k]) d[k] <= src_d[k];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int unsigned k = 0; k < DEPTH; k++) occupancy = occupancy + OW'(v[k]);
  end

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe (DEPTH=4, CLEAR_DATA=1): directed scenarios plus a randomized
// run checked against a queue model of words in flight.
module tb_elastic_pipe;
  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data;
  logic [2:0]   occupancy;
  int checks = 0;
  int errors = 0;

  typedef struct {logic [W-1:0] d; int t;} ent_t;

  always #5 clk = ~clk;

  elastic_pipe #(.WIDTH(W), .DEPTH(D), .CLEAR_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin in_data = 32'hA0 + W'(i); tick(); end
    in_valid = 1'b0; #1;
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL reset_prefill_occ got %0d exp 4", occupancy); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 22; c++) begin
      logic exp_v;
      in_valid = (c < 16);
      in_data  = W'(c + 1);
      #1;
      exp_v = (c >= 4) && (c < 20);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got %b exp 1", c, in_ready); end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL stream_out_valid c=%0d got %b exp %b", c, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_data !== W'(c - 3)) begin errors++; $display("FAIL stream_data c=%0d got %h exp %h", c, out_data, c - 3); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got[$];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = W'(i + 1); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_fill_ready i=%0d got %b exp 1", i, in_ready); end
      tick();
    end
    in_data = 32'h99;
    for (int h = 0; h < 3; h++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occ got %0d exp 4", occupancy); end
      checks++; if (out_valid !== 1'b1 || out_data !== 32'h1) begin errors++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=1", out_valid, out_data); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) got.push_back(out_data);
      tick();
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_drain_count got %0d exp 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++; if (got[i] !== W'(i + 1)) begin errors++; $display("FAIL bp_drain_order i=%0d got %h exp %h", i, got[i], i + 1); end
    end
  endtask

  task automatic test_bubble_collapse();
    logic [W-1:0] a = 32'hA5A5_0001;
    logic [W-1:0] b = 32'h5A5A_0002;
    do_reset();
    in_valid = 1'b1; in_data = a; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = b; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL bubble_occ got %0d exp 2", occupancy); end
    checks++; if (out_valid !== 1'b1 || out_data !== a) begin errors++; $display("FAIL bubble_head got v=%b d=%h exp v=1 d=%h", out_valid, out_data, a); end
    out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b1 || out_data !== a) begin errors++; $display("FAIL bubble_out_a got v=%b d=%h exp d=%h", out_valid, out_data, a); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== b) begin errors++; $display("FAIL bubble_out_b got v=%b d=%h exp d=%h", out_valid, out_data, b); end
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++; $display("FAIL bubble_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] sq[$];
    int nin = 0;
    int nout = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + W'(i); sq.push_back(in_data); tick();
    end
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = 32'h200 + W'(c); out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_in_ready c=%0d got %b exp 1", c, in_ready); end
      checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL simul_occ c=%0d got %0d exp 4", c, occupancy); end
      checks++; if (out_valid !== 1'b1 || out_data !== sq[0]) begin errors++; $display("FAIL simul_out c=%0d got v=%b d=%h exp v=1 d=%h", c, out_valid, out_data, sq[0]); end
      if (out_valid && out_ready && sq.size() > 0) begin void'(sq.pop_front()); nout++; end
      if (in_valid && in_ready) begin sq.push_back(in_data); nin++; end
      tick();
    end
    checks++; if (nin != 10 || nout != 10) begin errors++; $display("FAIL simul_counts got in=%0d out=%0d exp 10/10", nin, nout); end
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid) begin
        checks++;
        if (sq.size() == 0 || out_data !== sq[0]) begin errors++; $display("FAIL simul_drain got %h exp %h", out_data, (sq.size() > 0) ? sq[0] : 32'hx); end
        if (sq.size() > 0) void'(sq.pop_front());
      end
      tick();
    end
    checks++; if (sq.size() != 0 || occupancy !== 3'd0) begin errors++; $display("FAIL simul_leftover got left=%0d occ=%0d exp 0/0", sq.size(), occupancy); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin in_valid = 1'b1; in_data = 32'h301 + W'(i); tick(); end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL flush_pre_occ got %0d exp 3", occupancy); end
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1; #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h301) begin errors++; $display("FAIL flush_head_out got v=%b d=%h exp v=1 d=301", out_valid, out_data); end
    tick();
    flush = 1'b0; in_valid = 1'b0; #1;
    checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got occ=%0d v=%b exp 0/0", occupancy, out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL flush_data got %h exp 0", out_data); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped i=%0d got v=%b exp 0", i, out_valid); end
    end
  endtask

  // Each word is tagged with its accept cycle: the oldest word has no stage ahead of it,
  // so it reaches the output exactly D cycles after acceptance and stays until taken.
  task automatic test_random();
    ent_t q[$];
    int cyc = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic exp_rdy, exp_ov, fire_in, fire_out;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) < ((n / 50) % 4));
      in_data   = $urandom;
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      exp_rdy = out_ready || (q.size() < D);
      exp_ov  = (q.size() > 0) && (cyc - q[0].t >= D);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready n=%0d got %b exp %b", n, in_ready, exp_rdy); end
      checks++; if (int'(occupancy) != q.size()) begin errors++; $display("FAIL rand_occ n=%0d got %0d exp %0d", n, occupancy, q.size()); end
      checks++; if (out_valid !== exp_ov) begin errors++; $display("FAIL rand_out_valid n=%0d got %b exp %b", n, out_valid, exp_ov); end
      if (exp_ov) begin
        checks++; if (out_data !== q[0].d) begin errors++; $display("FAIL rand_out_data n=%0d got %h exp %h", n, out_data, q[0].d); end
      end
      fire_out = exp_ov && out_ready;
      fire_in  = in_valid && exp_rdy && !flush;
      if (fire_out) void'(q.pop_front());
      if (flush) q.delete();
      else if (fire_in) q.push_back('{d: in_data, t: cyc});
      tick();
      cyc++;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble_collapse();
    test_simultaneous();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
